rebeccargb_vga_pride: RTL and testbench

Standalone 640×480 @ 60 Hz VGA pattern generator that draws one of eight horizontally-striped pride flags full-screen. It is the top-level user design of a TinyTapeout tile: `ui_in` selects the flag, `uo_out` drives a TinyVGA PMOD (2 bits per colour channel, plus sync), and the bidirectional pins are unused.

---
 rtl/vga_pride_pkg.sv | 52 +++++
 rtl/vga_timing.sv | 47 ++++
 rtl/rebeccargb_vga_pride.sv | 103 ++++++++++
 tb/tb_rebeccargb_vga_pride.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pride_pkg.sv
// Shared definitions for the VGA pride-flag generator: 640x480@60 timing,
// flag indices, the 2-bit-per-channel colour type and the PMOD pin packing.
package vga_pride_pkg;

    // Horizontal timing in pixel clocks
    localparam int H_VISIBLE    = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    // Vertical timing in lines
    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Largest stripe count of any flag
    localparam int MAX_STRIPES  = 7;

    // Value on the PMOD while in reset: both syncs inactive (high), RGB off
    localparam logic [7:0] UO_RESET = 8'h88;

    typedef enum logic [2:0] {
        FLAG_RAINBOW   = 3'd0,
        FLAG_TRANS     = 3'd1,
        FLAG_BI        = 3'd2,
        FLAG_LESBIAN   = 3'd3,
        FLAG_PAN       = 3'd4,
        FLAG_ACE       = 3'd5,
        FLAG_NONBINARY = 3'd6,
        FLAG_AGENDER   = 3'd7
    } flag_e;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb222_t;

    // TinyVGA PMOD order: {HS, B0, G0, R0, VS, B1, G1, R1}
    function automatic logic [7:0] pmod_pack(input rgb222_t c, input logic hsync_n,
                                             input logic vsync_n);
        return {hsync_n, c.b[0], c.g[0], c.r[0], vsync_n, c.b[1], c.g[1], c.r[1]};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480 raster counters with active-low sync and visible-area decode.
module vga_timing
    import vga_pride_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [9:0] vpos_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o,
    output logic       visible_o,
    output logic       frame_start_o
);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       h_wrap;

    // Next raster position: hpos wraps every line, vpos steps on each line wrap
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        h_wrap = (hpos_q == 10'(H_TOTAL - 1));
        hpos_d = h_wrap ? 10'd0 : hpos_q + 10'd1;
        vpos_d = vpos_q;
        if (h_wrap) begin
            vpos_d = (vpos_q == 10'(V_TOTAL - 1)) ? 10'd0 : vpos_q + 10'd1;
        end
    end

    // Counter registers, cleared asynchronously to the top-left corner
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (rst_i) begin
            hpos_q <= '0;
            vpos_q <= '0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
        end
    end

    assign vpos_o        = vpos_q;
    assign hsync_n_o     = !((hpos_q >= 10'(H_SYNC_START)) && (hpos_q < 10'(H_SYNC_END)));
    assign vsync_n_o     = !((vpos_q >= 10'(V_SYNC_START)) && (vpos_q < 10'(V_SYNC_END)));
    assign visible_o     = (hpos_q < 10'(H_VISIBLE)) && (vpos_q < 10'(V_VISIBLE));
    assign frame_start_o = (hpos_q == 10'd0) && (vpos_q == 10'd0);

endmodule

// File: rtl/rebeccargb_vga_pride.sv
// TinyTapeout top: draws one of eight horizontally striped pride flags on a
// TinyVGA PMOD. The flag select is latched once per frame to avoid tearing.
module rebeccargb_vga_pride
    import vga_pride_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,   // active-high despite the template name
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Flag colours (RR_GG_BB), top stripe first; unused slots are black.
    // NOTE: a constant table needs no reset; only the registers below are reset.
    localparam logic [5:0] FLAG_ROM [8][8] = '{
        '{6'b11_00_00, 6'b11_10_00, 6'b11_11_00, 6'b00_10_00, 6'b00_00_11, 6'b10_00_10, 6'b0, 6'b0},
        '{6'b01_10_11, 6'b11_10_10, 6'b11_11_11, 6'b11_10_10, 6'b01_10_11, 6'b0, 6'b0, 6'b0},
        '{6'b11_00_10, 6'b11_00_10, 6'b10_01_10, 6'b00_01_11, 6'b00_01_11, 6'b0, 6'b0, 6'b0},
        '{6'b11_01_00, 6'b11_10_01, 6'b11_11_11, 6'b11_10_11, 6'b10_00_01, 6'b0, 6'b0, 6'b0},
        '{6'b11_00_10, 6'b11_11_00, 6'b00_10_11, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0},
        '{6'b00_00_00, 6'b10_10_10, 6'b11_11_11, 6'b10_00_10, 6'b0, 6'b0, 6'b0, 6'b0},
        '{6'b11_11_00, 6'b11_11_11, 6'b10_01_11, 6'b00_00_00, 6'b0, 6'b0, 6'b0, 6'b0},
        '{6'b00_00_00, 6'b10_10_10, 6'b11_11_11, 6'b10_11_01, 6'b11_11_11, 6'b10_10_10, 6'b00_00_00, 6'b0}
    };

    // Stripe index of a row for an n-stripe flag; n is always a constant at
    // the call site, so each boundary folds to a fixed 10-bit compare.
    function automatic logic [2:0] stripe_of(input logic [9:0] row, input int n);
        logic [2:0] idx;
        idx = '0;
        for (int k = 1; k < MAX_STRIPES; k++) begin
            if (k < n && row >= 10'((V_VISIBLE * k) / n)) begin
                idx = idx + 3'd1;
            end
        end
        return idx;
    endfunction

    logic [9:0] vpos;
    logic       hsync_n, vsync_n, visible, frame_start;
    flag_e      flag_q, flag_d;
    logic [2:0] stripe;
    rgb222_t    pixel;
    logic [7:0] uo_q, uo_d;
    logic       unused_inputs;

    vga_timing u_timing (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .vpos_o        (vpos),
        .hsync_n_o     (hsync_n),
        .vsync_n_o     (vsync_n),
        .visible_o     (visible),
        .frame_start_o (frame_start)
    );

    // Pick up a new flag only at the frame origin; pixel (0,0) already uses it
    assign flag_d = frame_start ? flag_e'(ui_in[2:0]) : flag_q;

    // Row to stripe index, using the stripe count of the active flag
    always_comb begin
        stripe = '0;
        case (flag_d)
            FLAG_PAN:                            stripe = stripe_of(vpos, 3);
            FLAG_ACE, FLAG_NONBINARY:            stripe = stripe_of(vpos, 4);
            FLAG_TRANS, FLAG_BI, FLAG_LESBIAN:   stripe = stripe_of(vpos, 5);
            FLAG_RAINBOW:                        stripe = stripe_of(vpos, 6);
            FLAG_AGENDER:                        stripe = stripe_of(vpos, 7);
            default:                             stripe = '0;
        endcase
    end

    // Colour lookup, blanked outside the visible area, packed for the PMOD
    always_comb begin
        pixel = '0;
        if (visible) begin
            pixel = rgb222_t'(FLAG_ROM[flag_d][stripe]);
        end
        uo_d = pmod_pack(pixel, hsync_n, vsync_n);
    end

    // Flag latch and registered PMOD output, one cycle behind the counters
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            flag_q <= FLAG_RAINBOW;
            uo_q   <= UO_RESET;
        end else begin
            flag_q <= flag_d;
            uo_q   <= uo_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Tile inputs that this design deliberately ignores
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_rebeccargb_vga_pride.sv
// Self-checking bench for rebeccargb_vga_pride. Expected pixels come from a
// bench-side model built from the flag boundary and colour tables; they are
// queued with the clock edge at which they must appear on uo_out.
module tb_rebeccargb_vga_pride;

    localparam int LINE  = 800;
    localparam int FRAME = 420000;

    // Stripe start rows per flag (1000 = no further stripe)
    localparam int BOUNDS [8][6] = '{
        '{80, 160, 240, 320, 400, 1000},
        '{96, 192, 288, 384, 1000, 1000},
        '{96, 192, 288, 384, 1000, 1000},
        '{96, 192, 288, 384, 1000, 1000},
        '{160, 320, 1000, 1000, 1000, 1000},
        '{120, 240, 360, 1000, 1000, 1000},
        '{120, 240, 360, 1000, 1000, 1000},
        '{68, 137, 205, 274, 342, 411}
    };

    // Stripe colours as decimal RGB digits (e.g. 320 = R3 G2 B0)
    localparam int COLOURS [8][7] = '{
        '{300, 320, 330, 20, 3, 202, 0},
        '{123, 322, 333, 322, 123, 0, 0},
        '{302, 302, 212, 13, 13, 0, 0},
        '{310, 321, 333, 323, 201, 0, 0},
        '{302, 330, 23, 0, 0, 0, 0},
        '{0, 222, 333, 202, 0, 0, 0},
        '{330, 333, 213, 0, 0, 0, 0},
        '{0, 222, 333, 231, 333, 222, 0}
    };

    typedef struct {
        int unsigned at_edge;
        logic [7:0]  exp;
        string       tag;
    } sb_item_t;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int          checks;
    int          errors;
    int unsigned edge_cnt;
    sb_item_t    sb_q[$];

    int unsigned hs_fall_q[$], hs_low_q[$], vs_fall_q[$], vs_low_q[$];
    int unsigned hs_run, vs_run;
    logic        hs_prev, vs_prev;

    rebeccargb_vga_pride dut (
        .clk     (clk),
        .rst_n   (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the last reset release
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Sync pulse monitor: records falling-edge times and low widths
    always @(negedge clk) begin
        if (rst) begin
            hs_prev <= 1'b1;
            vs_prev <= 1'b1;
            hs_run  <= 0;
            vs_run  <= 0;
        end else begin
            if (hs_prev && !uo_out[7]) hs_fall_q.push_back(edge_cnt);
            if (!uo_out[7]) hs_run <= hs_run + 1;
            else if (!hs_prev) begin
                hs_low_q.push_back(hs_run);
                hs_run <= 0;
            end
            hs_prev <= uo_out[7];
            if (vs_prev && !uo_out[3]) vs_fall_q.push_back(edge_cnt);
            if (!uo_out[3]) vs_run <= vs_run + 1;
            else if (!vs_prev) begin
                vs_low_q.push_back(vs_run);
                vs_run <= 0;
            end
            vs_prev <= uo_out[3];
        end
    end

    function automatic logic [7:0] model_px(input int f, input int h, input int v);
        int c;
        int s;
        logic [1:0] r, g, b;
        logic [7:0] o;
        c = 0;
        if (h < 640 && v < 480) begin
            s = 0;
            for (int k = 0; k < 6; k++) if (v >= BOUNDS[f][k]) s++;
            c = COLOURS[f][s];
        end
        r = 2'(c / 100);
        g = 2'((c / 10) % 10);
        b = 2'(c % 10);
        o[0] = r[1];
        o[1] = g[1];
        o[2] = b[1];
        o[3] = !(v >= 490 && v <= 491);
        o[4] = r[0];
        o[5] = g[0];
        o[6] = b[0];
        o[7] = !(h >= 656 && h <= 751);
        return o;
    endfunction

    task automatic push_px(input int frame, input int h, input int v, input int f,
                           input string tag);
        sb_item_t it;
        it.at_edge = frame * FRAME + v * LINE + h + 1;
        it.exp     = model_px(f, h, v);
        it.tag     = tag;
        sb_q.push_back(it);
    endtask

    task automatic drain();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            if (rst) begin
                it = sb_q.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: reset asserted while waiting, required 0x%02h", it.tag, it.exp);
            end else if (edge_cnt >= sb_q[0].at_edge) begin
                it = sb_q.pop_front();
                checks++;
                if (edge_cnt != it.at_edge) begin
                    errors++;
                    $display("FAIL %s: sample slot missed at edge %0d, required edge %0d",
                             it.tag, edge_cnt, it.at_edge);
                end else if (uo_out !== it.exp) begin
                    errors++;
                    $display("FAIL %s: uo_out=0x%02h required 0x%02h", it.tag, uo_out, it.exp);
                end
            end
        end
    endtask

    task automatic release_reset();
        hs_fall_q.delete();
        hs_low_q.delete();
        vs_fall_q.delete();
        vs_low_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        ena    = 1'b1;
        uio_in = 8'h5A;
        ui_in  = 8'b1010_1111;
        repeat (3) @(negedge clk);
        checks++;
        if (uo_out !== 8'h88) begin
            errors++;
            $display("FAIL reset_uo: uo_out=0x%02h required 0x88", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio_out: uio_out=0x%02h required 0x00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio_oe: uio_oe=0x%02h required 0x00", uio_oe);
        end
    endtask

    task automatic test_agender();
        release_reset();
        push_px(0, 0, 0, 7, "agender_0_0");
        push_px(0, 320, 67, 7, "agender_row67");
        push_px(0, 320, 68, 7, "agender_row68");
        drain();
    endtask

    task automatic test_async_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (uo_out !== 8'h88) begin
            errors++;
            $display("FAIL async_reset: uo_out=0x%02h required 0x88 before any edge", uo_out);
        end
        @(negedge clk);
        checks++;
        if (uo_out !== 8'h88) begin
            errors++;
            $display("FAIL reset_hold: uo_out=0x%02h required 0x88", uo_out);
        end
    endtask

    task automatic test_trans_frame();
        ui_in = 8'hF9;
        release_reset();
        push_px(0, 320, 95, 1, "trans_row95");
        push_px(0, 320, 96, 1, "trans_row96");
        push_px(0, 320, 192, 1, "trans_row192");
        push_px(0, 320, 288, 1, "trans_row288");
        drain();
        ui_in = 8'h00;
        push_px(0, 320, 384, 1, "trans_row384_after_sel_change");
        push_px(0, 0, 479, 1, "trans_row479");
        drain();
    endtask

    task automatic test_hsync();
        checks++;
        if (hs_fall_q.size() < 2 || hs_low_q.size() < 1) begin
            errors++;
            $display("FAIL hsync_seen: %0d falls recorded, required at least 2", hs_fall_q.size());
        end else begin
            if (hs_fall_q[0] != 657) begin
                errors++;
                $display("FAIL hsync_first_fall: edge %0d required 657", hs_fall_q[0]);
            end
            checks++;
            if (hs_low_q[0] != 96) begin
                errors++;
                $display("FAIL hsync_width: %0d cycles required 96", hs_low_q[0]);
            end
            checks++;
            if (hs_fall_q[1] - hs_fall_q[0] != 800) begin
                errors++;
                $display("FAIL hsync_period: %0d cycles required 800", hs_fall_q[1] - hs_fall_q[0]);
            end
        end
    endtask

    task automatic test_rainbow_frame();
        push_px(1, 320, 0, 0, "rainbow_row0");
        push_px(1, 640, 10, 0, "blank_640_10");
        push_px(1, 320, 160, 0, "rainbow_row160");
        push_px(1, 320, 199, 0, "rainbow_row199");
        drain();
        ui_in = 8'h04;
        push_px(1, 320, 200, 0, "rainbow_row200_after_sel_change");
        push_px(1, 320, 479, 0, "rainbow_row479");
        push_px(1, 320, 491, 0, "vblank_vsync_row491");
        drain();
    endtask

    task automatic test_pan_next_frame();
        push_px(2, 320, 0, 4, "pan_row0");
        push_px(2, 320, 159, 4, "pan_row159");
        push_px(2, 320, 160, 4, "pan_row160");
        drain();
    endtask

    task automatic test_vsync();
        checks++;
        if (vs_fall_q.size() < 2 || vs_low_q.size() < 1) begin
            errors++;
            $display("FAIL vsync_seen: %0d falls recorded, required at least 2", vs_fall_q.size());
        end else begin
            if (vs_fall_q[0] != 490 * LINE + 1) begin
                errors++;
                $display("FAIL vsync_first_fall: edge %0d required %0d", vs_fall_q[0], 490 * LINE + 1);
            end
            checks++;
            if (vs_low_q[0] != 1600) begin
                errors++;
                $display("FAIL vsync_width: %0d cycles required 1600", vs_low_q[0]);
            end
            checks++;
            if (vs_fall_q[1] - vs_fall_q[0] != FRAME) begin
                errors++;
                $display("FAIL vsync_period: %0d cycles required %0d", vs_fall_q[1] - vs_fall_q[0], FRAME);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_agender();
        test_async_reset();
        test_trans_frame();
        test_hsync();
        test_rainbow_frame();
        test_pan_next_frame();
        test_vsync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #30000000;
        $display("FAIL watchdog: run did not complete, %0d checks done, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
